// File: rtl/park_pkg.sv
// Shared types and helpers for the parking exit controller.
package park_pkg;

   localparam int unsigned MAX_SLOTS = 256;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      DONE,
      FAIL,
      LOCK
   } exit_state_e;

   // Isolates the lowest set bit; zero in gives zero out.
   function automatic logic [MAX_SLOTS-1:0] lowest_one_hot(input logic [MAX_SLOTS-1:0] v);
      return v & ((~v) + {{(MAX_SLOTS-1){1'b0}}, 1'b1});
   endfunction

endpackage

// File: rtl/park_slot_alloc.sv
// Combinational allocator: lowest-index free slot as one-hot, plus lot-full flag.
module park_slot_alloc
   import park_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 8
) (
   input  logic [NUM_SLOTS-1:0] occupancy,
   output logic [NUM_SLOTS-1:0] free_oh,
   output logic                 full
);

   logic [MAX_SLOTS-1:0] free_wide;
   logic [MAX_SLOTS-1:0] pick_wide;

   always_comb begin
      free_wide                  = '0;
      free_wide[NUM_SLOTS-1:0]   = ~occupancy;
      pick_wide                  = lowest_one_hot(free_wide);
   end

   assign free_oh = pick_wide[NUM_SLOTS-1:0];
   // Nothing to pick only when every slot is taken.
   assign full    = ~|pick_wide;

endmodule

// File: rtl/park_exit_ctrl.sv
// Parking lot controller: slot allocation on entry, token-checked release on exit.
//   state | meaning
//   IDLE  | accepting an exit request, captures token^pattern
//   CHECK | decoded slot range/occupancy test
//   DONE  | exit_done pulse, slot freed, fail count cleared
//   FAIL  | exit_err pulse, fail count bumped, maybe lock
//   LOCK  | exits refused for LOCK_CYCLES cycles
module park_exit_ctrl
   import park_pkg::*;
#(
   parameter int unsigned NUM_SLOTS   = 8,
   parameter int unsigned IDX_W       = $clog2(NUM_SLOTS),
   parameter int unsigned MAX_FAILS   = 3,
   parameter int unsigned LOCK_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enter_req,
   output logic                 enter_ack,
   output logic                 enter_nack,
   output logic [NUM_SLOTS-1:0] enter_slot,
   input  logic                 exit_valid,
   output logic                 exit_ready,
   input  logic [IDX_W-1:0]     token,
   input  logic [IDX_W-1:0]     pattern,
   output logic                 exit_done,
   output logic                 exit_err,
   output logic [NUM_SLOTS-1:0] park_location,
   output logic [NUM_SLOTS-1:0] occupancy,
   output logic [IDX_W:0]       free_count,
   output logic                 full,
   output logic                 locked
);

   localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
   localparam int unsigned LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAILS);
   localparam logic [LOCK_W-1:0] LOCK_LOAD  = LOCK_W'(LOCK_CYCLES - 1);
   localparam logic [IDX_W:0]    SLOT_LIMIT = (IDX_W + 1)'(NUM_SLOTS);

   exit_state_e          state_q, state_d;
   logic [IDX_W-1:0]     slot_q, slot_d;
   logic [FAIL_W-1:0]    fail_cnt_q, fail_cnt_d;
   logic [FAIL_W-1:0]    fail_next;
   logic [LOCK_W-1:0]    lock_cnt_q, lock_cnt_d;
   logic [NUM_SLOTS-1:0] occ_q, occ_d;
   logic [IDX_W:0]       free_cnt_q, free_cnt_d;
   logic                 full_q, full_d;
   logic                 enter_ack_q, enter_ack_d;
   logic                 enter_nack_q, enter_nack_d;
   logic [NUM_SLOTS-1:0] enter_slot_q, enter_slot_d;

   logic [NUM_SLOTS-1:0] alloc_oh;
   logic                 alloc_full;
   logic [NUM_SLOTS-1:0] slot_oh;
   logic                 slot_hit;

   park_slot_alloc #(.NUM_SLOTS(NUM_SLOTS)) u_alloc (
      .occupancy (occ_q),
      .free_oh   (alloc_oh),
      .full      (alloc_full)
   );

   assign slot_oh   = NUM_SLOTS'(1) << slot_q;
   assign slot_hit  = ({1'b0, slot_q} < SLOT_LIMIT) && (|(occ_q & slot_oh));
   assign fail_next = fail_cnt_q + FAIL_W'(1);

   always_comb begin
      state_d      = state_q;
      slot_d       = slot_q;
      fail_cnt_d   = fail_cnt_q;
      lock_cnt_d   = lock_cnt_q;
      occ_d        = occ_q;
      free_cnt_d   = free_cnt_q;
      enter_ack_d  = enter_req && !alloc_full;
      enter_nack_d = enter_req && alloc_full;
      enter_slot_d = enter_ack_d ? alloc_oh : '0;

      // Allocation sees pre-release occupancy, so a slot freed this cycle is not reused yet.
      if (enter_ack_d) begin
         occ_d      = occ_d | alloc_oh;
         free_cnt_d = free_cnt_d - (IDX_W + 1)'(1);
      end

      case (state_q)
         IDLE: begin
            if (exit_valid) begin
               slot_d  = token ^ pattern;
               state_d = CHECK;
            end
         end
         CHECK: state_d = slot_hit ? DONE : FAIL;
         DONE: begin
            occ_d      = occ_d & ~slot_oh;
            free_cnt_d = free_cnt_d + (IDX_W + 1)'(1);
            fail_cnt_d = '0;
            state_d    = IDLE;
         end
         FAIL: begin
            if (fail_next == FAIL_LIMIT) begin
               fail_cnt_d = '0;
               lock_cnt_d = LOCK_LOAD;
               state_d    = LOCK;
            end else begin
               fail_cnt_d = fail_next;
               state_d    = IDLE;
            end
         end
         LOCK: begin
            if (lock_cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               lock_cnt_d = lock_cnt_q - LOCK_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      full_d = &occ_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         slot_q       <= '0;
         fail_cnt_q   <= '0;
         lock_cnt_q   <= '0;
         occ_q        <= '0;
         free_cnt_q   <= SLOT_LIMIT;
         full_q       <= 1'b0;
         enter_ack_q  <= 1'b0;
         enter_nack_q <= 1'b0;
         enter_slot_q <= '0;
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         fail_cnt_q   <= fail_cnt_d;
         lock_cnt_q   <= lock_cnt_d;
         occ_q        <= occ_d;
         free_cnt_q   <= free_cnt_d;
         full_q       <= full_d;
         enter_ack_q  <= enter_ack_d;
         enter_nack_q <= enter_nack_d;
         enter_slot_q <= enter_slot_d;
      end
   end

   assign exit_ready    = (state_q == IDLE);
   assign exit_done     = (state_q == DONE);
   assign exit_err      = (state_q == FAIL);
   assign locked        = (state_q == LOCK);
   assign park_location = exit_done ? slot_oh : '0;
   assign occupancy     = occ_q;
   assign free_count    = free_cnt_q;
   assign full          = full_q;
   assign enter_ack     = enter_ack_q;
   assign enter_nack    = enter_nack_q;
   assign enter_slot    = enter_slot_q;

endmodule

// File: tb/tb_park_exit_ctrl.sv
// Scoreboarded bench for park_exit_ctrl: 8-slot main instance plus a 5-slot range-check instance.
module tb_park_exit_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   always #5 clk = ~clk;

   logic       enter_req = 1'b0, exit_valid = 1'b0;
   logic [2:0] token = '0, pattern = '0;
   logic       enter_ack, enter_nack, exit_ready, exit_done, exit_err, full, locked;
   logic [7:0] enter_slot, park_location, occupancy;
   logic [3:0] free_count;

   park_exit_ctrl #(.NUM_SLOTS(8), .MAX_FAILS(3), .LOCK_CYCLES(16)) u_dut (
      .clk(clk), .rst(rst),
      .enter_req(enter_req), .enter_ack(enter_ack), .enter_nack(enter_nack), .enter_slot(enter_slot),
      .exit_valid(exit_valid), .exit_ready(exit_ready), .token(token), .pattern(pattern),
      .exit_done(exit_done), .exit_err(exit_err), .park_location(park_location),
      .occupancy(occupancy), .free_count(free_count), .full(full), .locked(locked)
   );

   logic       exit_valid5 = 1'b0;
   logic [2:0] token5 = '0, pattern5 = '0;
   logic       enter_ack5, enter_nack5, exit_ready5, exit_done5, exit_err5, full5, locked5;
   logic [4:0] enter_slot5, park_location5, occupancy5;
   logic [3:0] free_count5;

   park_exit_ctrl #(.NUM_SLOTS(5), .MAX_FAILS(3), .LOCK_CYCLES(16)) u_dut5 (
      .clk(clk), .rst(rst),
      .enter_req(1'b0), .enter_ack(enter_ack5), .enter_nack(enter_nack5), .enter_slot(enter_slot5),
      .exit_valid(exit_valid5), .exit_ready(exit_ready5), .token(token5), .pattern(pattern5),
      .exit_done(exit_done5), .exit_err(exit_err5), .park_location(park_location5),
      .occupancy(occupancy5), .free_count(free_count5), .full(full5), .locked(locked5)
   );

   typedef struct {
      int         kind;   // 0 ack, 1 nack, 2 done, 3 err
      logic [7:0] oh;
      int         cyc;
   } ev_t;

   ev_t enter_q[$];
   ev_t exit_q[$];
   ev_t me, mx;
   int  cyc = 0;
   int  n_vec = 0;
   int  n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops expected events whenever the DUT pulses, flags missed or unexpected ones.
   always @(negedge clk) begin
      if (!rst) begin
         if (enter_ack || enter_nack) begin
            n_vec++;
            if (enter_q.size() == 0) begin
               n_bad++;
               $display("FAIL enter_unexpected: ack=%0b nack=%0b slot=%0h at cycle %0d", enter_ack, enter_nack, enter_slot, cyc);
            end else begin
               me = enter_q.pop_front();
               if (me.kind != (enter_ack ? 0 : 1) || me.cyc != cyc || (enter_ack && enter_slot !== me.oh)) begin
                  n_bad++;
                  $display("FAIL enter_event: got ack=%0b slot=%0h cycle %0d, expected kind=%0d slot=%0h cycle %0d",
                           enter_ack, enter_slot, cyc, me.kind, me.oh, me.cyc);
               end
            end
         end else if (enter_q.size() > 0 && enter_q[0].cyc < cyc) begin
            me = enter_q.pop_front();
            n_vec++; n_bad++;
            $display("FAIL enter_missed: no pulse, expected kind=%0d slot=%0h at cycle %0d", me.kind, me.oh, me.cyc);
         end

         if (exit_done || exit_err) begin
            n_vec++;
            if (exit_q.size() == 0) begin
               n_bad++;
               $display("FAIL exit_unexpected: done=%0b err=%0b loc=%0h at cycle %0d", exit_done, exit_err, park_location, cyc);
            end else begin
               mx = exit_q.pop_front();
               if (mx.kind != (exit_done ? 2 : 3) || mx.cyc != cyc || park_location !== mx.oh) begin
                  n_bad++;
                  $display("FAIL exit_event: got done=%0b loc=%0h cycle %0d, expected kind=%0d loc=%0h cycle %0d",
                           exit_done, park_location, cyc, mx.kind, mx.oh, mx.cyc);
               end
            end
         end else if (exit_q.size() > 0 && exit_q[0].cyc < cyc) begin
            mx = exit_q.pop_front();
            n_vec++; n_bad++;
            $display("FAIL exit_missed: no pulse, expected kind=%0d loc=%0h at cycle %0d", mx.kind, mx.oh, mx.cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_enter(input logic [7:0] exp_oh, input bit exp_nack);
      ev_t e;
      e.kind = exp_nack ? 1 : 0;
      e.oh   = exp_oh;
      e.cyc  = cyc + 1;
      enter_q.push_back(e);
      enter_req = 1'b1;
      tick();
      enter_req = 1'b0;
   endtask

   // Returns one cycle after the handshake (DUT in CHECK).
   task automatic do_exit(input logic [2:0] tok, input logic [2:0] pat, input bit expect_it,
                          input bit exp_err, input logic [7:0] exp_oh);
      ev_t e;
      int  w;
      w = 0;
      while (!exit_ready && w < 50) begin
         tick();
         w++;
      end
      check("exit_ready_wait", exit_ready, 1);
      if (expect_it) begin
         e.kind = exp_err ? 3 : 2;
         e.oh   = exp_err ? 8'h00 : exp_oh;
         e.cyc  = cyc + 2;
         exit_q.push_back(e);
      end
      exit_valid = 1'b1;
      token      = tok;
      pattern    = pat;
      tick();
      exit_valid = 1'b0;
      token      = ~tok;   // scramble inputs: the captured value must be used
      pattern    = 3'b010;
   endtask

   int lock_cnt, ready_viol;

   initial begin
      repeat (2) tick();
      rst = 1'b0;
      check("rst_occupancy", occupancy, 8'h00);
      check("rst_free_count", free_count, 8);
      check("rst_full", full, 0);
      check("rst_exit_ready", exit_ready, 1);
      check("rst_locked", locked, 0);
      check("rst_park_location", park_location, 8'h00);
      check("rst_enter_slot", enter_slot, 8'h00);

      do_enter(8'h01, 0);
      do_enter(8'h02, 0);
      do_enter(8'h04, 0);
      tick();
      check("fill3_occupancy", occupancy, 8'h07);
      check("fill3_free_count", free_count, 5);

      do_exit(3'b110, 3'b100, 1, 0, 8'h04);
      repeat (2) tick();
      check("exit2_occupancy", occupancy, 8'h03);
      check("exit2_free_count", free_count, 6);

      do_exit(3'b101, 3'b000, 1, 1, 8'h00);
      do_exit(3'b111, 3'b010, 1, 1, 8'h00);
      do_exit(3'b001, 3'b100, 1, 1, 8'h00);
      tick();   // third FAIL cycle
      check("fail3_not_yet_locked", locked, 0);
      lock_cnt   = 0;
      ready_viol = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (i == 3) begin
            enter_q.push_back('{kind: 0, oh: 8'h04, cyc: cyc + 1});
            enter_req = 1'b1;
         end else begin
            enter_req = 1'b0;
         end
         if (locked) begin
            lock_cnt++;
            if (exit_ready) ready_viol++;
         end
      end
      check("lock_cycles", lock_cnt, 16);
      check("lock_exit_ready_low", ready_viol, 0);
      check("lock_end_ready", exit_ready, 1);
      check("lock_occupancy", occupancy, 8'h07);
      check("lock_free_count", free_count, 5);

      do_enter(8'h08, 0);
      do_enter(8'h10, 0);
      do_enter(8'h20, 0);
      do_enter(8'h40, 0);
      do_enter(8'h80, 0);
      do_enter(8'h00, 1);
      check("full_flag", full, 1);
      check("full_occupancy", occupancy, 8'hFF);
      check("full_free_count", free_count, 0);

      do_exit(3'b011, 3'b000, 1, 0, 8'h08);
      tick();   // DONE cycle: entry still sees full lot
      do_enter(8'h00, 1);
      check("simul_occupancy", occupancy, 8'hF7);
      check("simul_free_count", free_count, 1);
      check("simul_full", full, 0);
      do_enter(8'h08, 0);
      check("refill_occupancy", occupancy, 8'hFF);

      do_exit(3'b000, 3'b000, 0, 0, 8'h01);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_occupancy", occupancy, 8'h00);
      check("midrst_free_count", free_count, 8);
      check("midrst_exit_ready", exit_ready, 1);
      check("midrst_exit_done", exit_done, 0);
      check("midrst_exit_err", exit_err, 0);
      tick();
      check("midrst_exit_done_next", exit_done, 0);
      check("midrst_exit_err_next", exit_err, 0);
      do_enter(8'h01, 0);

      check("n5_ready", exit_ready5, 1);
      exit_valid5 = 1'b1;
      token5      = 3'b110;
      pattern5    = 3'b000;
      tick();
      exit_valid5 = 1'b0;
      token5      = 3'b000;
      tick();
      check("n5_exit_err", exit_err5, 1);
      check("n5_exit_done", exit_done5, 0);
      check("n5_park_location", park_location5, 5'h00);
      tick();
      check("n5_fail_count", u_dut5.fail_cnt_q, 1);
      check("n5_ready_after", exit_ready5, 1);
      check("n5_locked", locked5, 0);

      repeat (5) tick();
      check("enter_queue_drained", enter_q.size(), 0);
      check("exit_queue_drained", exit_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish by 100000 time units");
      $fatal(1);
   end

endmodule

// File: doc/park_exit_ctrl.md
Name: park_exit_ctrl

Overview:
- Parametrised, clocked successor to the combinational parking-exit path.
- Owns the lot occupancy register and allocates the lowest free slot on entry.
- On exit, decrypts a token against a pattern, checks that the decoded slot is occupied, frees it, and reports a one-hot location.
- Adds a ready/valid exit handshake, error reporting, and brute-force lockout after repeated bad tokens.

Parameters:
- NUM_SLOTS, 8, number of parking slots (2..256)
- IDX_W, $clog2(NUM_SLOTS), width of token/pattern/slot index
- MAX_FAILS, 3, consecutive rejected exits that trigger lockout (>=1)
- LOCK_CYCLES, 16, lockout duration in clock cycles (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- enter_req  in  1  one-cycle request to park a car
- enter_ack  out  1  pulse: slot allocated
- enter_nack  out  1  pulse: lot full, request dropped
- enter_slot  out  NUM_SLOTS  one-hot allocated slot, valid with enter_ack
- exit_valid  in  1  exit request present
- exit_ready  out  1  block can accept an exit
- token  in  IDX_W  encrypted token, sampled on handshake
- pattern  in  IDX_W  key pattern, sampled on handshake
- exit_done  out  1  pulse: exit accepted, slot freed
- exit_err  out  1  pulse: exit rejected
- park_location  out  NUM_SLOTS  one-hot freed slot, valid with exit_done, else 0
- occupancy  out  NUM_SLOTS  bit i = slot i occupied
- free_count  out  IDX_W+1  number of free slots
- full  out  1  occupancy all ones
- locked  out  1  lockout active

Behaviour:
- Single clock domain clk. rst is synchronous, active-high.
- Reset values:
  - occupancy = 0, free_count = NUM_SLOTS, full = 0.
  - All pulses = 0, enter_slot = 0, park_location = 0.
  - locked = 0, fail counter = 0, state IDLE, exit_ready = 1 after reset deasserts.
- Decrypt: slot_num = token XOR pattern. The captured value is used, not the live inputs.
- Exit FSM: IDLE, CHECK, DONE, FAIL, LOCK.
  - IDLE: exit_ready = 1. On exit_valid && exit_ready, capture slot_num and go to CHECK.
  - CHECK: if slot_num < NUM_SLOTS and occupancy[slot_num] = 1, go to DONE; otherwise go to FAIL.
  - DONE (one cycle): exit_done = 1, park_location = 1<<slot_num, clear occupancy bit, fail counter = 0, go to IDLE.
  - FAIL (one cycle): exit_err = 1, fail counter += 1. If the counter reaches MAX_FAILS, go to LOCK with the counter cleared; otherwise go to IDLE.
  - LOCK: locked = 1, exit_ready = 0. Down-counter loaded with LOCK_CYCLES-1; return to IDLE when it reaches 0, so locked is high for exactly LOCK_CYCLES cycles.
- Exit latency: handshake at cycle T gives exit_done/exit_err high during cycle T+2. exit_ready = 0 in CHECK, DONE, FAIL and LOCK.
- Entry path is independent of the FSM and is served in every state, including LOCK.
  - enter_req && !full: set the lowest-index free bit; enter_ack and enter_slot are registered next cycle.
  - enter_req && full: enter_nack next cycle, occupancy unchanged.
- Simultaneous entry and release in the same cycle:
  - Entry allocation uses the pre-release occupancy. A slot freed this cycle is not reused until the next cycle.
  - Both updates apply, and free_count stays consistent.
- free_count and full are registered alongside occupancy.
- Reset mid-operation returns everything to reset values at the next edge. Any in-flight exit is discarded with no pulse.

Decomposition:
- Package park_pkg holds the FSM state enum (IDLE/CHECK/DONE/FAIL/LOCK) and a function for lowest-set-bit one-hot.
- Sub-module park_slot_alloc (combinational): takes occupancy, returns lowest free one-hot and a full flag. Instantiated once.

Test Plan:
- Reset, then 3 enter_req pulses -> enter_slot = 0x01, 0x02, 0x04; occupancy = 0x07; free_count = 5.
- Occupancy 0x07, token=3'b110, pattern=3'b100 (slot 2) -> exit_done at T+2, park_location = 0x04, occupancy = 0x03.
- Occupancy 0x03, token^pattern = 5 (free) three times -> three exit_err pulses; locked = 1 for 16 cycles; exit_ready = 0 throughout; entry still acked.
- 8 entries, then a 9th -> full = 1, enter_nack, occupancy = 0xFF. Same cycle, exit slot 3 with enter_req -> exit_done, enter_nack, occupancy = 0xF7, next entry gets 0x08.
- Exit held in CHECK, rst asserted -> next cycle occupancy = 0, no exit_done/exit_err, exit_ready = 1.
- NUM_SLOTS=5, token^pattern = 6 -> exit_err (out of range); fail counter = 1.
